// File: rtl/pipelined_add_acc_pkg.sv
// Shared definitions for the pipelined adder/accumulator.
//   MODE_W : width of the transaction mode field
//   mode_t : operation selected per accepted transaction
package add_acc_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ADD  = 2'b00,
    MODE_SADD = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/pipelined_add_acc_if.sv
// Operand/result handshake bundle for pipelined_add_acc.
//   input side : in_valid, in_ready, in_a, in_b, in_ch, in_mode
//   output side: out_valid, out_ready, out_sum, out_carry, out_sat, out_ch
//   master : environment view (drives operands, accepts results)
//   slave  : block view
interface pipelined_add_acc_if
  import add_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) ();

  localparam int CH_W = $clog2(NCH);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [CH_W-1:0]   in_ch;
  logic [MODE_W-1:0] in_mode;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_sum;
  logic              out_carry;
  logic              out_sat;
  logic [CH_W-1:0]   out_ch;

  modport master (
    output in_valid, in_a, in_b, in_ch, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_sat, out_ch
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ch, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_sat, out_ch
  );

endinterface

// File: rtl/pipelined_add_acc_add_sat.sv
// Combinational WIDTH-bit unsigned adder with optional saturation.
//   a, b   : operands
//   sat_en : clamp to all ones when the add overflows
//   sum    : result (wrapped or clamped)
//   carry  : unsigned carry-out, reported whether or not clamping applied
//   sat    : result was clamped
module add_sat_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sat_en,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             sat
);

  logic [WIDTH:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    carry = full[WIDTH];
    sat   = sat_en & full[WIDTH];
    sum   = sat ? {WIDTH{1'b1}} : full[WIDTH-1:0];
  end

endmodule

// File: rtl/pipelined_add_acc.sv
// Pipelined add / saturating add / per-channel accumulate / per-channel load.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : operand and result handshake (slave side)
//   op_count : accepted transactions since reset, wrapping
// One registered output stage; in_ready is combinational so a streaming
// consumer sees no bubbles.
module pipelined_add_acc
  import add_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipelined_add_acc_if.slave bus,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] acc [NCH];

  logic             accept;
  mode_t            mode;
  logic [WIDTH-1:0] acc_cur;

  logic [WIDTH-1:0] op_sum;
  logic             op_carry;
  logic             op_sat;
  logic [WIDTH-1:0] acc_sum;
  logic             acc_carry;
  logic             acc_sat;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign mode         = mode_t'(bus.in_mode);
  assign acc_cur      = acc[bus.in_ch];

  add_sat_unit #(.WIDTH(WIDTH)) u_op_add (
    .a      (bus.in_a),
    .b      (bus.in_b),
    .sat_en (mode == MODE_SADD),
    .sum    (op_sum),
    .carry  (op_carry),
    .sat    (op_sat)
  );

  // Accumulator path always wraps, so its sat output is constant zero.
  add_sat_unit #(.WIDTH(WIDTH)) u_acc_add (
    .a      (acc_cur),
    .b      (bus.in_a),
    .sat_en (1'b0),
    .sum    (acc_sum),
    .carry  (acc_carry),
    .sat    (acc_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_carry <= 1'b0;
      bus.out_sat   <= 1'b0;
      bus.out_ch    <= '0;
      op_count      <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
      end
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_ch    <= bus.in_ch;
      op_count      <= op_count + 1'b1;
      case (mode)
        MODE_ADD, MODE_SADD: begin
          bus.out_sum   <= op_sum;
          bus.out_carry <= op_carry;
          bus.out_sat   <= op_sat;
        end
        MODE_ACC: begin
          // Written in the accept cycle so a following ACC on the same
          // channel reads the updated value directly.
          acc[bus.in_ch] <= acc_sum;
          bus.out_sum    <= acc_sum;
          bus.out_carry  <= acc_carry;
          bus.out_sat    <= acc_sat;
        end
        default: begin
          acc[bus.in_ch] <= bus.in_b;
          bus.out_sum    <= bus.in_b;
          bus.out_carry  <= 1'b0;
          bus.out_sat    <= 1'b0;
        end
      endcase
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_add_acc.sv
// Self-checking bench for pipelined_add_acc (WIDTH=8, NCH=4, CNT_W=16).
module tb_pipelined_add_acc;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CNT_W = 16;

  localparam int M_ADD  = 0;
  localparam int M_SADD = 1;
  localparam int M_ACC  = 2;
  localparam int M_LOAD = 3;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] op_count;

  pipelined_add_acc_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  pipelined_add_acc #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one pending result slot plus per-channel accumulators.
  int acc_m [NCH];
  bit pend;
  int exp_sum, exp_carry, exp_sat, exp_ch;
  int cnt_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    pend  = 1'b0;
    cnt_m = 0;
    for (int i = 0; i < NCH; i++) acc_m[i] = 0;
  endtask

  task automatic model_accept(input int a, input int b, input int ch, input int mode);
    int s;
    exp_ch  = ch;
    exp_sat = 0;
    case (mode)
      M_ADD: begin
        s = a + b;
        exp_sum = s % 256; exp_carry = (s > 255) ? 1 : 0;
      end
      M_SADD: begin
        s = a + b;
        exp_carry = (s > 255) ? 1 : 0;
        if (s > 255) begin exp_sum = 255; exp_sat = 1; end
        else exp_sum = s;
      end
      M_ACC: begin
        s = acc_m[ch] + a;
        acc_m[ch] = s % 256;
        exp_sum = acc_m[ch]; exp_carry = (s > 255) ? 1 : 0;
      end
      default: begin
        acc_m[ch] = b;
        exp_sum = b; exp_carry = 0;
      end
    endcase
    pend  = 1'b1;
    cnt_m = (cnt_m + 1) % 65536;
  endtask

  // Drives one cycle of stimulus (called at posedge+1), checks all outputs
  // against the model at the falling edge, then advances the model.
  task automatic step(input bit v, input int a, input int b, input int ch,
                      input int mode, input bit ordy);
    bus.in_valid  = v;
    bus.in_a      = a[WIDTH-1:0];
    bus.in_b      = b[WIDTH-1:0];
    bus.in_ch     = ch[1:0];
    bus.in_mode   = mode[1:0];
    bus.out_ready = ordy;
    @(negedge clk);
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!pend || ordy)});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, pend});
    if (pend) begin
      check("out_sum", {24'd0, bus.out_sum}, exp_sum);
      check("out_carry", {31'd0, bus.out_carry}, exp_carry);
      check("out_sat", {31'd0, bus.out_sat}, exp_sat);
      check("out_ch", {30'd0, bus.out_ch}, exp_ch);
    end
    check("op_count", {16'd0, op_count}, cnt_m);
    if (v && (!pend || ordy)) model_accept(a, b, ch, mode);
    else if (ordy) pend = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step_rand(input bit ordy);
    step(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ordy);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_ch     = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // 1. reset state and zeroed accumulators
    check("init_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int c = 0; c < NCH; c++) begin
      step(1'b1, 0, 0, c, M_ACC, 1'b1);
      check("acc_init_zero", {24'd0, bus.out_sum}, 32'd0);
    end

    // 2. add modes
    step(1'b1, 200, 100, 0, M_ADD, 1'b1);
    check("add_sum", {24'd0, bus.out_sum}, 32'd44);
    check("add_carry", {31'd0, bus.out_carry}, 32'd1);
    check("add_sat", {31'd0, bus.out_sat}, 32'd0);
    step(1'b1, 200, 100, 0, M_SADD, 1'b1);
    check("sadd_sum", {24'd0, bus.out_sum}, 32'd255);
    check("sadd_carry", {31'd0, bus.out_carry}, 32'd1);
    check("sadd_sat", {31'd0, bus.out_sat}, 32'd1);
    step(1'b1, 10, 20, 0, M_SADD, 1'b1);
    check("sadd_small_sum", {24'd0, bus.out_sum}, 32'd30);
    check("sadd_small_sat", {31'd0, bus.out_sat}, 32'd0);

    // 3. streaming accumulate, isolation, load
    step(1'b1, 100, 0, 1, M_ACC, 1'b1);
    check("acc1_a", {24'd0, bus.out_sum}, 32'd100);
    step(1'b1, 100, 0, 1, M_ACC, 1'b1);
    check("acc1_b", {24'd0, bus.out_sum}, 32'd200);
    step(1'b1, 100, 0, 1, M_ACC, 1'b1);
    check("acc1_c", {24'd0, bus.out_sum}, 32'd44);
    check("acc1_c_carry", {31'd0, bus.out_carry}, 32'd1);
    step(1'b1, 0, 0, 2, M_ACC, 1'b1);
    check("acc2_iso", {24'd0, bus.out_sum}, 32'd0);
    step(1'b1, 0, 7, 1, M_LOAD, 1'b1);
    check("load1", {24'd0, bus.out_sum}, 32'd7);
    step(1'b1, 1, 0, 1, M_ACC, 1'b1);
    check("acc1_after_load", {24'd0, bus.out_sum}, 32'd8);

    // 4. backpressure
    do_reset();
    step(1'b1, 5, 6, 0, M_ADD, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 9, 9, 0, M_ADD, 1'b0);
      check("bp_hold_sum", {24'd0, bus.out_sum}, 32'd11);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    step(1'b1, 9, 9, 0, M_ADD, 1'b1);
    check("bp_second_sum", {24'd0, bus.out_sum}, 32'd18);
    step(1'b0, 0, 0, 0, M_ADD, 1'b1);
    check("bp_op_count", {16'd0, op_count}, 32'd2);
    check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

    // 5. reset with a pending result
    step(1'b1, 0, 50, 3, M_LOAD, 1'b0);
    step(1'b0, 0, 0, 0, M_ADD, 1'b0);
    check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    do_reset();
    step(1'b1, 0, 0, 3, M_ACC, 1'b1);
    check("acc3_cleared", {24'd0, bus.out_sum}, 32'd0);

    // random traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b0, 0, 0, 0, M_ADD, 1'($urandom_range(0, 1)));
      else
        step_rand(1'($urandom_range(0, 3) != 0));
    end

    // 6. counter wrap
    do_reset();
    for (int i = 0; i < 65536; i++) step_rand(1'b1);
    check("op_count_wrap", {16'd0, op_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
